// File: rtl/sum_share_arbiter.sv
// Round-robin arbiter that time-shares one registered W-bit adder among NREQ
// requesters, returning a (W+1)-bit sum tagged with the granted requester id.
module sum_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [W:0]        res_sum,
  output logic              busy,
  output logic [7:0]        ops_cnt
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] gnt_next;
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IDW-1:0]  id_q;

  // The current grant holder is masked so a lone requester cannot hog the adder.
  assign eligible = en ? (req & ~gnt) : '0;

  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    gnt_next = '0;
    a_sel    = '0;
    b_sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_found && (win_id == IDW'(i))) begin
        gnt_next[i] = 1'b1;
        a_sel       = op_a[i*W +: W];
        b_sel       = op_b[i*W +: W];
      end
    end
  end

  // Explicit wrap keeps non-power-of-two NREQ correct (e.g. 2 -> 0 for NREQ=3).
  assign ptr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt  <= '0;
      ptr  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
    end else begin
      gnt <= gnt_next;
      if (win_found) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= win_id;
        ptr  <= ptr_next;
      end
    end
  end

  // Adder stage: any grant issued last edge completes now, even with en low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
      ops_cnt   <= '0;
    end else begin
      res_valid <= |gnt;
      if (|gnt) begin
        res_sum <= {1'b0, a_q} + {1'b0, b_q};
        res_id  <= id_q;
        ops_cnt <= ops_cnt + 8'd1;
      end
    end
  end

  assign busy = (|gnt) | res_valid;

endmodule

// File: tb/tb_sum_share_arbiter.sv
// Directed bench for sum_share_arbiter: a reference model predicts grants and
// pushes expected sums to a scoreboard that is popped on every res_valid.
module tb_sum_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W:0]     sum;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [W:0]        res_sum;
  logic              busy;
  logic [7:0]        ops_cnt;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int             m_ptr;
  logic [NREQ-1:0] m_gnt;
  logic           m_rv;
  logic [7:0]     m_cnt;
  logic [IDW-1:0] m_last_id;
  logic [W:0]     m_last_sum;

  sum_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .busy(busy), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Winner is the eligible index at the smallest round-robin distance from p.
  function automatic int pickWinner(input logic [NREQ-1:0] elig, input int p);
    int best  = -1;
    int bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i]) begin
        int d;
        d = (i - p + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic setOp(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [NREQ-1:0] rq);
    logic [NREQ-1:0] elig;
    int              w;
    res_t            ent;
    rst_n = r;
    en    = e;
    req   = rq;
    @(posedge clk);
    if (!r) begin
      m_gnt      = '0;
      m_ptr      = 0;
      m_rv       = 1'b0;
      m_cnt      = '0;
      m_last_id  = '0;
      m_last_sum = '0;
      sb.delete();
    end else begin
      m_rv = |m_gnt;
      if (m_rv) m_cnt = m_cnt + 8'd1;
      elig = e ? (rq & ~m_gnt) : '0;
      w = pickWinner(elig, m_ptr);
      if (w >= 0) begin
        m_gnt   = '0;
        m_gnt[w] = 1'b1;
        ent.id  = IDW'(w);
        ent.sum = {1'b0, op_a[w*W +: W]} + {1'b0, op_b[w*W +: W]};
        sb.push_back(ent);
        m_ptr = (w + 1) % NREQ;
      end else begin
        m_gnt = '0;
      end
    end
    #1;
    checkOutput("gnt", 32'(gnt), 32'(m_gnt));
    checkOutput("res_valid", 32'(res_valid), 32'(m_rv));
    checkOutput("ops_cnt", 32'(ops_cnt), 32'(m_cnt));
    checkOutput("busy", 32'(busy), 32'((|m_gnt) | m_rv));
    if (res_valid === 1'b1) begin
      checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        ent = sb.pop_front();
        checkOutput("res_id", 32'(res_id), 32'(ent.id));
        checkOutput("res_sum", 32'(res_sum), 32'(ent.sum));
        m_last_id  = ent.id;
        m_last_sum = ent.sum;
      end
    end else begin
      checkOutput("res_id_hold", 32'(res_id), 32'(m_last_id));
      checkOutput("res_sum_hold", 32'(res_sum), 32'(m_last_sum));
    end
  endtask

  initial begin
    logic [NREQ-1:0] t2_gnt [5];
    logic [W:0]      t2_sum [4];
    t2_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t2_sum = '{5'd3, 5'd5, 5'd7, 5'd9};
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    op_a  = '0;
    op_b  = '0;

    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("rst_ops_cnt", 32'(ops_cnt), 32'd0);

    // Single transaction: 7 + 9 = 16 needs the carry bit
    setOp(0, 4'd7, 4'd9);
    applyStimulus(1'b1, 1'b1, 4'b0001);
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("t1_valid", 32'(res_valid), 32'd1);
    checkOutput("t1_sum", 32'(res_sum), 32'd16);
    checkOutput("t1_cnt", 32'(ops_cnt), 32'd1);
    checkOutput("t1_gnt_off", 32'(gnt), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("t1_idle", 32'(res_valid), 32'd0);

    // All four requesting: strict rotation
    applyStimulus(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < NREQ; i++) setOp(i, W'(i + 1), W'(i + 2));
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 4'b1111);
      checkOutput($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(t2_gnt[k]));
      if (k > 0) checkOutput($sformatf("t2_sum%0d", k), 32'(res_sum), 32'(t2_sum[k-1]));
    end
    applyStimulus(1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000);

    // Lone requester: granted every other cycle, busy never drops
    setOp(2, 4'd15, 4'd15);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b1, 4'b0100);
      checkOutput($sformatf("t3_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h4 : 32'h0);
      checkOutput($sformatf("t3_busy%0d", k), 32'(busy), 32'd1);
      if (k % 2 == 1) checkOutput($sformatf("t3_sum%0d", k), 32'(res_sum), 32'd30);
    end
    applyStimulus(1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000);

    // en low blocks new grants but lets the in-flight result finish
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0011);
    checkOutput("t4_gnt0", 32'(gnt), 32'h1);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    checkOutput("t4_valid", 32'(res_valid), 32'd1);
    checkOutput("t4_id", 32'(res_id), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    checkOutput("t4_blocked", 32'(gnt), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0011);
    checkOutput("t4_resume", 32'(gnt), 32'h2);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000);

    // Reset while a result is pending discards it
    setOp(1, 4'd3, 4'd4);
    applyStimulus(1'b1, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    checkOutput("t5_valid", 32'(res_valid), 32'd0);
    checkOutput("t5_sum", 32'(res_sum), 32'd0);
    checkOutput("t5_cnt", 32'(ops_cnt), 32'd0);
    setOp(3, 4'd8, 4'd1);
    applyStimulus(1'b1, 1'b1, 4'b1000);
    checkOutput("t5_gnt", 32'(gnt), 32'h8);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("t5_id", 32'(res_id), 32'd3);
    applyStimulus(1'b1, 1'b1, 4'b1001);
    checkOutput("t5_ptr_wrap", 32'(gnt), 32'h1);
    applyStimulus(1'b1, 1'b1, 4'b0000);

    // ops_cnt wraps after 256 results
    applyStimulus(1'b0, 1'b1, 4'b0000);
    for (int k = 0; k < 256; k++) begin
      setOp(0, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      setOp(1, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      applyStimulus(1'b1, 1'b1, 4'b0011);
    end
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("t6_wrap", 32'(ops_cnt), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0001);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("t6_after", 32'(ops_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
